// File: rtl/cti_counter_table_if.sv
// Bundle between the fetch/predict path and the CTI counter table.
// The master drives reads, updates and flush; the slave returns data and status.
interface cti_counter_table_if #(
  parameter int INDEX   = 4,
  parameter int WIDTH   = 8,
  parameter int NUM_RD  = 2,
  parameter int NUM_UPD = 4
);
  logic                      flush;
  logic [NUM_RD*INDEX-1:0]   rd_addr;
  logic [NUM_RD*WIDTH-1:0]   rd_data;
  logic [NUM_UPD*INDEX-1:0]  upd_addr;
  logic [NUM_UPD*2-1:0]      upd_op;
  logic [NUM_UPD*WIDTH-1:0]  upd_data;
  logic                      busy;
  logic [NUM_UPD-1:0]        sat_evt;

  modport master (
    output flush, rd_addr, upd_addr, upd_op, upd_data,
    input  rd_data, busy, sat_evt
  );

  modport slave (
    input  flush, rd_addr, upd_addr, upd_op, upd_data,
    output rd_data, busy, sat_evt
  );
endinterface

// File: rtl/cti_counter_table.sv
// Multi-port saturating CTI counter table with merged RMW updates and sequential clear.
// Optional write-through forwarding on reads: define CTI_COUNTER_BYPASS_EN.
module cti_counter_table #(
  parameter int DEPTH   = 16,
  parameter int INDEX   = 4,
  parameter int WIDTH   = 8,
  parameter int NUM_RD  = 2,
  parameter int NUM_UPD = 4
) (
  input  logic               clk,
  input  logic               reset,
  cti_counter_table_if.slave bus
);
  localparam int DW = WIDTH + 4;
  localparam logic [INDEX-1:0] LAST = INDEX'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [INDEX-1:0]   clr_ptr, ptr_nxt;
  logic               busy, upd_en;
  logic [NUM_UPD-1:0] sat_evt, sat_nxt;

  logic [WIDTH-1:0]        ram    [DEPTH];
  logic [WIDTH-1:0]        nxt    [DEPTH];
  logic [WIDTH-1:0]        ld_val [DEPTH];
  logic signed [DW-1:0]    delta  [DEPTH];
  logic                    hit    [DEPTH];
  logic                    ld_hit [DEPTH];
  logic                    clamp  [DEPTH];
  logic [NUM_RD*WIDTH-1:0] rd_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      sat_evt <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= ptr_nxt;
      sat_evt <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    busy      = 1'b0;
    upd_en    = 1'b0;
    unique case (state)
      IDLE: begin
        upd_en = 1'b1;
        if (bus.flush) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (bus.flush) begin
          ptr_nxt = '0;
        end else if (clr_ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = clr_ptr + INDEX'(1);
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Gather every lane's contribution per entry; later loads override earlier ones.
  always_comb begin
    logic [INDEX-1:0]     a;
    logic [1:0]           op;
    logic signed [DW-1:0] sum;
    a   = '0;
    op  = '0;
    sum = '0;
    for (int e = 0; e < DEPTH; e++) begin
      hit[e]    = 1'b0;
      ld_hit[e] = 1'b0;
      ld_val[e] = '0;
      delta[e]  = '0;
      clamp[e]  = 1'b0;
      nxt[e]    = ram[e];
    end
    if (upd_en) begin
      for (int l = 0; l < NUM_UPD; l++) begin
        a  = bus.upd_addr[l*INDEX +: INDEX];
        op = bus.upd_op[l*2 +: 2];
        if (int'(a) < DEPTH && op != 2'b00) begin
          hit[a] = 1'b1;
          unique case (1'b1)
            op == 2'b11: begin
              ld_hit[a] = 1'b1;
              ld_val[a] = bus.upd_data[l*WIDTH +: WIDTH];
            end
            op == 2'b01: delta[a] = delta[a] + DW'(1);
            default:     delta[a] = delta[a] - DW'(1);
          endcase
        end
      end
    end
    for (int e = 0; e < DEPTH; e++) begin
      sum = $signed({4'b0000, ram[e]}) + delta[e];
      if (ld_hit[e]) begin
        nxt[e] = ld_val[e];
      end else if (sum[DW-1]) begin
        nxt[e]   = '0;
        clamp[e] = 1'b1;
      end else if (|sum[DW-2:WIDTH]) begin
        nxt[e]   = '1;
        clamp[e] = 1'b1;
      end else begin
        nxt[e] = sum[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    logic [INDEX-1:0] a;
    logic [1:0]       op;
    a       = '0;
    op      = '0;
    sat_nxt = '0;
    for (int l = 0; l < NUM_UPD; l++) begin
      a  = bus.upd_addr[l*INDEX +: INDEX];
      op = bus.upd_op[l*2 +: 2];
      if (upd_en && int'(a) < DEPTH && (op == 2'b01 || op == 2'b10))
        sat_nxt[l] = clamp[a];
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      ram[clr_ptr] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++)
        if (hit[e]) ram[e] <= nxt[e];
    end
  end

  always_comb begin
    logic [INDEX-1:0] ra;
    ra     = '0;
    rd_vec = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = bus.rd_addr[p*INDEX +: INDEX];
      if (!busy && int'(ra) < DEPTH) begin
`ifdef CTI_COUNTER_BYPASS_EN
        rd_vec[p*WIDTH +: WIDTH] = hit[ra] ? nxt[ra] : ram[ra];
`else
        rd_vec[p*WIDTH +: WIDTH] = ram[ra];
`endif
      end
    end
  end

  assign bus.rd_data = rd_vec;
  assign bus.busy    = busy;
  assign bus.sat_evt = sat_evt;
endmodule

// File: tb/tb_cti_counter_table.sv
// Scoreboard bench for cti_counter_table: expectations are queued at stimulus
// time and compared once the DUT result is visible.
module tb_cti_counter_table;
  localparam int DEPTH = 16, INDEX = 4, WIDTH = 8, NUM_RD = 2, NUM_UPD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cti_counter_table_if #(.INDEX(INDEX), .WIDTH(WIDTH), .NUM_RD(NUM_RD),
                         .NUM_UPD(NUM_UPD)) bus ();

  cti_counter_table #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH),
                      .NUM_RD(NUM_RD), .NUM_UPD(NUM_UPD)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    string       name;
    int          kind;
    int          addr;
    logic [31:0] val;
  } item_t;

  item_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ops();
    bus.upd_op   = '0;
    bus.upd_addr = '0;
    bus.upd_data = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic [1:0] op,
                          input int addr, input logic [7:0] d);
    bus.upd_op[l*2 +: 2]       = op;
    bus.upd_addr[l*INDEX +: INDEX] = INDEX'(addr);
    bus.upd_data[l*WIDTH +: WIDTH] = d;
  endtask

  task automatic exp_rd(input string n, input int addr, input int v);
    q.push_back('{n, 0, addr, 32'(v)});
  endtask

  task automatic exp_sat(input string n, input int v);
    q.push_back('{n, 1, 0, 32'(v)});
  endtask

  task automatic observe(input item_t it, output logic [31:0] obs);
    int p;
    p = it.addr % NUM_RD;
    if (it.kind == 0) begin
      bus.rd_addr[p*INDEX +: INDEX] = INDEX'(it.addr);
      #1;
      obs = 32'(bus.rd_data[p*WIDTH +: WIDTH]);
    end else begin
      obs = 32'(bus.sat_evt);
    end
  endtask

  task automatic test_reset();
    item_t it;
    logic [31:0] obs;
    int n;
    idle_ops();
    bus.rd_addr = '0;
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (bus.busy !== 1'b1 || bus.sat_evt !== 4'b0) begin
      bad++;
      $display("FAIL reset_state: busy=%b sat=%b want busy=1 sat=0000", bus.busy, bus.sat_evt);
    end
    reset = 1'b0;
    bus.rd_addr[3:0] = 4'd15;
    #1;
    total++;
    if (bus.rd_data[7:0] !== 8'h00) begin
      bad++;
      $display("FAIL busy_read_zero: got %h want 00", bus.rd_data[7:0]);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL clear_length: got %0d cycles want 16", n);
    end
    for (int e = 0; e < DEPTH; e++) exp_rd($sformatf("cleared_%0d", e), e, 0);
    while (q.size() > 0) begin
      it = q.pop_front();
      observe(it, obs);
      total++;
      if (obs !== it.val) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", it.name, obs, it.val);
      end
    end
  endtask

  task automatic test_inc_merge();
    item_t it;
    logic [31:0] obs;
    set_lane(0, 2'b11, 5, 8'd3);
    tick();
    idle_ops();
    for (int l = 0; l < 3; l++) set_lane(l, 2'b01, 5, 8'd0);
    tick();
    idle_ops();
    exp_sat("inc3_sat", 0);
    exp_rd("inc3_val", 5, 6);
    while (q.size() > 0) begin
      it = q.pop_front();
      observe(it, obs);
      total++;
      if (obs !== it.val) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", it.name, obs, it.val);
      end
    end
  endtask

  task automatic test_saturation();
    item_t it;
    logic [31:0] obs;
    set_lane(0, 2'b11, 9, 8'd254);
    tick();
    idle_ops();
    set_lane(0, 2'b01, 9, 8'd0);
    set_lane(1, 2'b01, 9, 8'd0);
    tick();
    idle_ops();
    exp_sat("hi_clamp_sat", 4'b0011);
    exp_rd("hi_clamp_val", 9, 255);
    while (q.size() > 0) begin
      it = q.pop_front();
      observe(it, obs);
      total++;
      if (obs !== it.val) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", it.name, obs, it.val);
      end
    end
    tick();
    set_lane(3, 2'b10, 2, 8'd0);
    tick();
    idle_ops();
    exp_sat("lo_clamp_sat", 4'b1000);
    exp_rd("lo_clamp_val", 2, 0);
    while (q.size() > 0) begin
      it = q.pop_front();
      observe(it, obs);
      total++;
      if (obs !== it.val) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", it.name, obs, it.val);
      end
    end
    tick();
    exp_sat("sat_clears", 0);
    while (q.size() > 0) begin
      it = q.pop_front();
      observe(it, obs);
      total++;
      if (obs !== it.val) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", it.name, obs, it.val);
      end
    end
  endtask

  task automatic test_load_priority();
    item_t it;
    logic [31:0] obs;
    set_lane(1, 2'b11, 4, 8'h40);
    set_lane(3, 2'b11, 4, 8'h7F);
    set_lane(0, 2'b01, 4, 8'h00);
    tick();
    idle_ops();
    exp_sat("load_prio_sat", 0);
    exp_rd("load_prio_val", 4, 8'h7F);
    while (q.size() > 0) begin
      it = q.pop_front();
      observe(it, obs);
      total++;
      if (obs !== it.val) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", it.name, obs, it.val);
      end
    end
  endtask

  task automatic test_flush_restart();
    item_t it;
    logic [31:0] obs;
    int n;
    idle_ops();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL flush_busy: got %b want 1", bus.busy);
    end
    exp_rd("busy_masks_entry4", 4, 0);
    while (q.size() > 0) begin
      it = q.pop_front();
      observe(it, obs);
      total++;
      if (obs !== it.val) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", it.name, obs, it.val);
      end
    end
    repeat (10) tick();
    bus.flush = 1'b1;
    set_lane(0, 2'b11, 3, 8'h55);
    set_lane(1, 2'b10, 3, 8'h00);
    tick();
    bus.flush = 1'b0;
    total++;
    if (bus.sat_evt !== 4'b0) begin
      bad++;
      $display("FAIL clear_sat: got %b want 0000", bus.sat_evt);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    idle_ops();
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL restart_length: got %0d cycles want 16", n);
    end
    exp_rd("ignored_upd_3", 3, 0);
    exp_rd("recleared_4", 4, 0);
    exp_rd("recleared_9", 9, 0);
    while (q.size() > 0) begin
      it = q.pop_front();
      observe(it, obs);
      total++;
      if (obs !== it.val) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", it.name, obs, it.val);
      end
    end
  endtask

  task automatic test_bypass();
    item_t it;
    logic [31:0] obs;
    set_lane(0, 2'b11, 7, 8'd1);
    tick();
    idle_ops();
    set_lane(0, 2'b01, 7, 8'd0);
`ifdef CTI_COUNTER_BYPASS_EN
    exp_rd("bypass_same_cycle", 7, 2);
`else
    exp_rd("bypass_same_cycle", 7, 1);
`endif
    while (q.size() > 0) begin
      it = q.pop_front();
      observe(it, obs);
      total++;
      if (obs !== it.val) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", it.name, obs, it.val);
      end
    end
    tick();
    idle_ops();
    exp_rd("bypass_next_cycle", 7, 2);
    while (q.size() > 0) begin
      it = q.pop_front();
      observe(it, obs);
      total++;
      if (obs !== it.val) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", it.name, obs, it.val);
      end
    end
  endtask

  task automatic test_random_merge();
    item_t it;
    logic [31:0] obs;
    int m[DEPTH];
    int inc[4], dec[4], lv[4], s;
    bit ld[4], cl[4];
    int op[NUM_UPD], ad[NUM_UPD], dv[NUM_UPD];
    int sat;
    int edge_vals[4] = '{0, 1, 254, 255};
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < NUM_UPD; l++) begin
        s = edge_vals[$urandom_range(0, 3)];
        m[c*4+l] = s;
        set_lane(l, 2'b11, c*4+l, 8'(s));
      end
      tick();
    end
    idle_ops();
    for (int it_n = 0; it_n < 40; it_n++) begin
      for (int e = 0; e < 4; e++) begin
        inc[e] = 0; dec[e] = 0; ld[e] = 0; lv[e] = 0; cl[e] = 0;
      end
      for (int l = 0; l < NUM_UPD; l++) begin
        op[l] = $urandom_range(0, 3);
        ad[l] = $urandom_range(0, 3);
        dv[l] = edge_vals[$urandom_range(0, 3)];
        set_lane(l, 2'(op[l]), ad[l], 8'(dv[l]));
        if (op[l] == 3) begin ld[ad[l]] = 1; lv[ad[l]] = dv[l]; end
        else if (op[l] == 1) inc[ad[l]]++;
        else if (op[l] == 2) dec[ad[l]]++;
      end
      for (int e = 0; e < 4; e++) begin
        if (ld[e]) m[e] = lv[e];
        else begin
          s = m[e] + inc[e] - dec[e];
          if (s < 0) begin m[e] = 0; cl[e] = 1; end
          else if (s > 255) begin m[e] = 255; cl[e] = 1; end
          else m[e] = s;
        end
      end
      sat = 0;
      for (int l = 0; l < NUM_UPD; l++)
        if ((op[l] == 1 || op[l] == 2) && cl[ad[l]]) sat |= (1 << l);
      tick();
      idle_ops();
      exp_sat($sformatf("rand%0d_sat", it_n), sat);
      for (int e = 0; e < 4; e++) exp_rd($sformatf("rand%0d_e%0d", it_n, e), e, m[e]);
      while (q.size() > 0) begin
        it = q.pop_front();
        observe(it, obs);
        total++;
        if (obs !== it.val) begin
          bad++;
          $display("FAIL %s: got %0h want %0h", it.name, obs, it.val);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.rd_addr = '0;
    idle_ops();
    test_reset();
    test_inc_merge();
    test_saturation();
    test_load_priority();
    test_flush_restart();
    test_bypass();
    test_random_merge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
